// File: rtl/cordic_iter_engine.sv
// rtl/cordic_iter_engine.sv - iterative rotation/vectoring CORDIC core with full-circle quadrant correction
module cordic_iter_engine #(
   parameter int WIDTH = 16,
   parameter int ITERS = 14,
   parameter int GUARD = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    mode,
   input  logic signed [WIDTH-1:0] x_in,
   input  logic signed [WIDTH-1:0] y_in,
   input  logic signed [WIDTH-1:0] z_in,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [WIDTH-1:0] x_out,
   output logic signed [WIDTH-1:0] y_out,
   output logic signed [WIDTH-1:0] z_out,
   output logic                    busy
);

   localparam int WG = WIDTH + GUARD;
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(ITERS - 1);
   localparam real PI_R = 3.14159265358979323846;

   // Angle landmarks in the pi/2^(WIDTH-1) angle format
   localparam logic signed [WIDTH-1:0] HALF_PI     = {2'b01, {(WIDTH-2){1'b0}}};
   localparam logic signed [WIDTH-1:0] NEG_HALF_PI = {2'b11, {(WIDTH-2){1'b0}}};
   localparam logic signed [WIDTH-1:0] PI_NEG      = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic signed [WIDTH-1:0] PI_POS      = {1'b0, {(WIDTH-1){1'b1}}};

   typedef enum logic [1:0] {S_IDLE, S_PRE, S_ITER, S_DONE} state_t;

   // atan(2^-i) scaled to the angle format; arctan series for i>0, exact pi/4 for i=0
   function automatic logic signed [WIDTH-1:0] atan_lut(input int i);
      real t, p, r, scale;
      t = 1.0;
      for (int j = 0; j < i; j++) t = t / 2.0;
      r = 0.0;
      p = t;
      if (i == 0) begin
         r = PI_R / 4.0;
      end else begin
         for (int k = 0; k < 24; k++) begin
            if (k % 2 == 0) r = r + p / real'(2 * k + 1);
            else            r = r - p / real'(2 * k + 1);
            p = p * t * t;
         end
      end
      scale = 1.0;
      for (int j = 1; j < WIDTH; j++) scale = scale * 2.0;
      scale = scale / PI_R;
      return WIDTH'($rtoi(r * scale + 0.5));
   endfunction

   // Clamp the guarded accumulator into the output range
   function automatic logic signed [WIDTH-1:0] sat(input logic signed [WG-1:0] v);
      if ((v[WG-1:WIDTH-1] == '0) || (v[WG-1:WIDTH-1] == '1)) return v[WIDTH-1:0];
      else if (v[WG-1])                                       return PI_NEG;
      else                                                    return PI_POS;
   endfunction

   logic signed [WIDTH-1:0] atan_tab [2**CW];

   for (genvar g = 0; g < 2**CW; g++) begin : g_atan
      if (g < ITERS) begin : g_used
         localparam logic signed [WIDTH-1:0] A = atan_lut(g);
         assign atan_tab[g] = A;
      end else begin : g_pad
         assign atan_tab[g] = '0;
      end
   end

   state_t                  state_q;
   logic [CW-1:0]           iter_q;
   logic                    mode_q;
   logic signed [WG-1:0]    x_q, y_q, x_d, y_d, xs, ys;
   logic signed [WIDTH-1:0] z_q, z_d;
   logic                    out_valid_q;
   logic signed [WIDTH-1:0] x_out_q, y_out_q, z_out_q;
   logic                    dir;
   logic                    accept;

   assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
   assign accept    = in_valid && in_ready;
   assign busy      = (state_q == S_PRE) || (state_q == S_ITER);
   assign out_valid = out_valid_q;
   assign x_out     = x_out_q;
   assign y_out     = y_out_q;
   assign z_out     = z_out_q;

   // Next datapath value: quadrant pre-rotation in PRE, one micro-rotation otherwise
   always_comb begin
      xs  = x_q >>> iter_q;
      ys  = y_q >>> iter_q;
      dir = mode_q ? y_q[WG-1] : ~z_q[WIDTH-1];
      if (dir) begin
         x_d = x_q - ys;
         y_d = y_q + xs;
         z_d = z_q - atan_tab[iter_q];
      end else begin
         x_d = x_q + ys;
         y_d = y_q - xs;
         z_d = z_q + atan_tab[iter_q];
      end
      if (state_q == S_PRE) begin
         x_d = x_q;
         y_d = y_q;
         z_d = z_q;
         if (mode_q) begin
            z_d = '0;
            if (x_q[WG-1]) begin
               x_d = -x_q;
               y_d = -y_q;
               z_d = y_q[WG-1] ? PI_NEG : PI_POS;
            end
         end else if ((z_q > HALF_PI) || (z_q < NEG_HALF_PI)) begin
            // +pi and -pi are the same offset modulo 2pi
            x_d = -x_q;
            y_d = -y_q;
            z_d = z_q + PI_NEG;
         end
      end
   end

   // Control FSM with operand latch, iteration counter and registered results
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         iter_q      <= '0;
         mode_q      <= 1'b0;
         x_q         <= '0;
         y_q         <= '0;
         z_q         <= '0;
         out_valid_q <= 1'b0;
         x_out_q     <= '0;
         y_out_q     <= '0;
         z_out_q     <= '0;
      end else if (accept) begin
         state_q     <= S_PRE;
         iter_q      <= '0;
         mode_q      <= mode;
         x_q         <= {{GUARD{x_in[WIDTH-1]}}, x_in};
         y_q         <= {{GUARD{y_in[WIDTH-1]}}, y_in};
         z_q         <= z_in;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_PRE: begin
               x_q     <= x_d;
               y_q     <= y_d;
               z_q     <= z_d;
               iter_q  <= '0;
               state_q <= S_ITER;
            end
            S_ITER: begin
               x_q <= x_d;
               y_q <= y_d;
               z_q <= z_d;
               if (iter_q == LAST) begin
                  iter_q      <= '0;
                  state_q     <= S_DONE;
                  out_valid_q <= 1'b1;
                  x_out_q     <= sat(x_d);
                  y_out_q     <= sat(y_d);
                  z_out_q     <= z_d;
               end else begin
                  iter_q <= iter_q + CW'(1);
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_iter_engine.sv
// tb/tb_cordic_iter_engine.sv - directed self-checking bench for cordic_iter_engine
module tb_cordic_iter_engine;

   localparam int W = 16;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                in_valid = 1'b0;
   logic                mode = 1'b0;
   logic                out_ready = 1'b0;
   logic signed [W-1:0] x_in = '0;
   logic signed [W-1:0] y_in = '0;
   logic signed [W-1:0] z_in = '0;
   logic                in_ready, out_valid, busy;
   logic signed [W-1:0] x_out, y_out, z_out;

   int tests = 0;
   int failed = 0;

   always #5 clk = ~clk;

   cordic_iter_engine #(.WIDTH(16), .ITERS(14), .GUARD(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .x_in      (x_in),
      .y_in      (y_in),
      .z_in      (z_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .x_out     (x_out),
      .y_out     (y_out),
      .z_out     (z_out),
      .busy      (busy)
   );

   task automatic check_eq(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_near(input string tag, input logic signed [31:0] obs, input int exp, input int tol);
      int diff;
      tests++;
      diff = obs - exp;
      assert (!$isunknown(obs) && diff >= -tol && diff <= tol)
      else begin
         failed++;
         $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, tol);
      end
   endtask

   // Present one operand set, accept on the next edge, then scramble the inputs
   task automatic issue(input logic m, input int x, input int y, input int z);
      @(negedge clk);
      mode     = m;
      x_in     = W'(x);
      y_in     = W'(y);
      z_in     = W'(z);
      in_valid = 1'b1;
      check_eq("in_ready_at_issue", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      mode     = ~m;
      x_in     = 16'sh1234;
      y_in     = -16'sh2345;
      z_in     = 16'sh7000;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (out_valid !== 1'b1 && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_eq({tag, "_out_valid"}, out_valid, 1);
   endtask

   task automatic drain();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check_eq("drain_out_valid", out_valid, 0);
      check_eq("drain_in_ready", in_ready, 1);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_in_ready", in_ready, 1);
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_x_out", x_out, 0);
      check_eq("rst_y_out", y_out, 0);
      check_eq("rst_z_out", z_out, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Rotation by pi/4 with exact latency check
      issue(1'b0, 16'h4DBA, 0, 16'h2000);
      check_eq("rot_busy_pre", busy, 1);
      repeat (14) @(posedge clk);
      #1;
      check_eq("rot_not_yet_valid", out_valid, 0);
      check_eq("rot_busy_iter", busy, 1);
      @(posedge clk);
      #1;
      check_eq("rot_valid_at_latency", out_valid, 1);
      check_eq("rot_busy_done", busy, 0);
      check_eq("rot_in_ready_stalled", in_ready, 0);
      check_near("rot_x", x_out, 16'h5A82, 4);
      check_near("rot_y", y_out, 16'h5A82, 4);
      check_near("rot_z_residual", z_out, 0, 4);
      drain();

      // Rotation by 3pi/4 exercises the quadrant correction
      issue(1'b0, 16'h4DBA, 0, 16'h6000);
      wait_done("quad");
      check_near("quad_x", x_out, -16'sh5A82, 4);
      check_near("quad_y", y_out, 16'h5A82, 4);
      drain();

      // Saturation: gain pushes both results above full scale
      issue(1'b0, 16'h7FFF, 16'h7FFF, 0);
      wait_done("sat");
      check_eq("sat_x", x_out, 16'sh7FFF);
      check_eq("sat_y", y_out, 16'sh7FFF);
      drain();

      // Vectoring in the second quadrant, then a 10-cycle stall with stray in_valid
      issue(1'b1, -16'sh3000, 16'h3000, 0);
      wait_done("vec2");
      @(negedge clk);
      in_valid = 1'b1;
      mode     = 1'b0;
      x_in     = 16'h0100;
      y_in     = 16'h0100;
      z_in     = 16'h0100;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         check_eq("stall_in_ready", in_ready, 0);
         check_eq("stall_out_valid", out_valid, 1);
         check_near("stall_vec2_z", z_out, 16'h6000, 4);
         check_near("stall_vec2_x", x_out, 16'h6FCB, 4);
      end

      // Same-edge drain and refill with a first-quadrant vectoring op
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      mode      = 1'b1;
      x_in      = 16'h3000;
      y_in      = 16'h3000;
      z_in      = 16'h1111;
      #1;
      check_eq("b2b_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      check_eq("b2b_out_valid_low", out_valid, 0);
      check_eq("b2b_busy", busy, 1);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      x_in      = -16'sh4000;
      wait_done("vec1");
      check_near("vec1_z", z_out, 16'h2000, 4);
      check_near("vec1_x", x_out, 16'h6FCB, 4);
      check_near("vec1_y", y_out, 0, 4);
      drain();

      // Reset in the middle of the iterations
      issue(1'b0, 16'h4DBA, 0, 16'h2000);
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("midrst_out_valid", out_valid, 0);
      check_eq("midrst_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_eq("midrst_in_ready", in_ready, 1);
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #1;
         if (out_valid !== 1'b0) seen = 1'b1;
      end
      check_eq("midrst_no_out_valid", seen, 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
